johnson_decoder: RTL

JOHNSON_DECODER -- requirements
Module: johnson_decoder

---
 rtl/johnson_pkg.sv | 18 +
 rtl/johnson_code_check.sv | 34 +++
 rtl/johnson_decoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code decoder.
package johnson_pkg;

  // Sequence-tracking states
  typedef enum logic {
    ACQ,
    LOCKED
  } jd_state_e;

  localparam int unsigned JD_N_DEF        = 4;
  localparam int unsigned JD_LOCK_CNT_DEF = 3;

  // Width of a decoded index covering 0..2n-1
  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and index decode of one Johnson code word.
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int unsigned N     = JD_N_DEF,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     code,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  localparam logic [N-1:0] ONES = '1;

  // Compare against every legal word: k ones from the MSB (idx k),
  // then N-j ones at the LSB end (idx N+j)
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k <= N; k++) begin
      if (code == ~(ONES >> k)) begin
        legal = 1'b1;
        idx   = IDX_W'(k);
      end
    end
    for (int unsigned j = 1; j < N; j++) begin
      if (code == (ONES >> j)) begin
        legal = 1'b1;
        idx   = IDX_W'(N + j);
      end
    end
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence lock tracking and saturating error count.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned N        = JD_N_DEF,
  parameter int unsigned LOCK_CNT = JD_LOCK_CNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          code_in,
  input  logic                  code_vld,
  input  logic                  clr_err,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  idx_vld,
  output logic                  locked,
  output logic                  err_code,
  output logic                  err_seq,
  output logic [7:0]            err_cnt
);

  localparam int unsigned IDX_W = idx_w(N);

  jd_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       run_q, run_d;
  logic             ref_q, ref_d;
  logic             idx_vld_d, err_code_d, err_seq_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             legal;
  logic [IDX_W-1:0] dec_idx;
  logic [IDX_W-1:0] succ;
  logic             is_succ, is_hold;
  logic [3:0]       run_inc;
  logic             err_any;

  johnson_code_check #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_check (
    .code  (code_in),
    .legal (legal),
    .idx   (dec_idx)
  );

  // Successor relation against the last legal index (wraps 2N-1 -> 0)
  always_comb begin
    succ    = (idx_q == IDX_W'(2 * N - 1)) ? '0 : idx_q + 1'b1;
    is_succ = (dec_idx == succ);
    is_hold = (dec_idx == idx_q);
    run_inc = run_q + 4'd1;
  end

  // Next-state, index update and error pulse generation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_d      = run_q;
    ref_d      = ref_q;
    idx_vld_d  = 1'b0;
    err_code_d = 1'b0;
    err_seq_d  = 1'b0;
    if (code_vld) begin
      if (!legal) begin
        err_code_d = 1'b1;
        state_d    = ACQ;
        run_d      = '0;
        ref_d      = 1'b0;
      end else begin
        idx_d     = dec_idx;
        idx_vld_d = 1'b1;
        ref_d     = 1'b1;
        unique case (state_q)
          ACQ: begin
            if (!ref_q) begin
              run_d = '0;
            end else if (is_succ) begin
              if (run_inc >= 4'(LOCK_CNT)) begin
                state_d = LOCKED;
                run_d   = '0;
              end else begin
                run_d = run_inc;
              end
            end else if (!is_hold) begin
              run_d = '0;
            end
          end
          LOCKED: begin
            if (!(is_succ || is_hold)) begin
              err_seq_d = 1'b1;
              state_d   = ACQ;
              run_d     = '0;
            end
          end
          default: state_d = ACQ;
        endcase
      end
    end
  end

  // Error counter: clear wins over history but still counts a coincident error
  always_comb begin
    err_any = err_code_d | err_seq_d;
    if (clr_err) begin
      cnt_d = err_any ? 8'd1 : 8'd0;
    end else if (err_any && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACQ;
      idx_q    <= '0;
      run_q    <= '0;
      ref_q    <= 1'b0;
      idx_vld  <= 1'b0;
      err_code <= 1'b0;
      err_seq  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      run_q    <= run_d;
      ref_q    <= ref_d;
      idx_vld  <= idx_vld_d;
      err_code <= err_code_d;
      err_seq  <= err_seq_d;
      cnt_q    <= cnt_d;
    end
  end

  assign idx     = idx_q;
  assign locked  = (state_q == LOCKED);
  assign err_cnt = cnt_q;

endmodule
